// File: rtl/note_seq_pkg.sv
// Shared types for the note sequencer: FSM state encoding and the stored melody entry.
package note_seq_pkg;

    localparam int PERIOD_W = 32;
    localparam int DUR_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        FINISH
    } state_t;

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [DUR_W-1:0]    dur;
    } entry_t;

endpackage

// File: rtl/note_sequencer_tick_gen.sv
// Free-running divider producing a 1-cycle tick every CLK_HZ/TICK_HZ clocks;
// clr restarts the count so the first tick lands a full period later.
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Melody player feeding freq_pwm: steps through stored (period, duration) entries with a
// silent gap between notes. Define NOTE_SEQ_LOOP_EN to add the `loop` input (repeat until stop).
//
// Handshake: start/stop are single-cycle pulses with no ready; start is honoured only when
// busy=0, stop only when busy=1, stop wins when both are high. wr_en is accepted only when busy=0.
// new_period and done are 1-cycle pulses with no back-pressure.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000,
    parameter int GAP_MS  = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [PERIOD_W-1:0]        wr_period,
    input  logic [DUR_W-1:0]           wr_dur,
    input  logic [$clog2(DEPTH):0]     seq_len,
    input  logic [2:0]                 octave,
    input  logic                       start,
    input  logic                       stop,
`ifdef NOTE_SEQ_LOOP_EN
    input  logic                       loop,
`endif
    output logic [PERIOD_W-1:0]        clks_per_period,
    output logic                       new_period,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   cur_index,
    output state_t                     state_dbg
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(DEPTH);
    localparam logic [DUR_W-1:0] GAP_TICKS = DUR_W'(GAP_MS);

    entry_t              mem [DEPTH];
    entry_t              rd_q;
    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [2:0]          oct_q, oct_d;
    logic [PERIOD_W-1:0] cpp_q, cpp_d;
    logic                np_q, np_d;
    logic                done_q, done_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [DUR_W-1:0]    gap_q, gap_d;
    logic                loop_q, loop_d;
    logic                tick, tick_clr, last, adv;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Read address follows the next index so the entry is ready during LOAD.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE) begin
            mem[wr_addr] <= '{period: wr_period, dur: wr_dur};
        end
        rd_q <= mem[idx_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            oct_q   <= '0;
            cpp_q   <= '0;
            np_q    <= 1'b0;
            done_q  <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            oct_q   <= oct_d;
            cpp_q   <= cpp_d;
            np_q    <= np_d;
            done_q  <= done_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            loop_q  <= loop_d;
        end
    end

    assign last = ({1'b0, idx_q} == len_q - 1'b1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        oct_d    = oct_q;
        cpp_d    = cpp_q;
        np_d     = 1'b0;
        done_d   = 1'b0;
        dur_d    = dur_q;
        gap_d    = gap_q;
        loop_d   = loop_q;
        tick_clr = 1'b0;
        adv      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (seq_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = LOAD;
                        idx_d    = '0;
                        len_d    = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
                        oct_d    = octave;
                        tick_clr = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                        loop_d   = loop;
`else
                        loop_d   = 1'b0;
`endif
                    end
                end
            end
            LOAD: begin
                cpp_d   = rd_q.period >> oct_q;
                np_d    = 1'b1;
                dur_d   = (rd_q.dur == '0) ? DUR_W'(1) : rd_q.dur;
                state_d = PLAY;
            end
            PLAY: begin
                // The count hits zero on the last tick; the note is released one cycle later.
                if (dur_q == '0) begin
                    if (GAP_MS > 0) begin
                        cpp_d   = '0;
                        np_d    = 1'b1;
                        gap_d   = GAP_TICKS;
                        state_d = GAP;
                    end else begin
                        adv = 1'b1;
                    end
                end else if (tick) begin
                    dur_d = dur_q - 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q <= DUR_W'(1)) begin
                        adv = 1'b1;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            FINISH: begin
                cpp_d   = '0;
                np_d    = (cpp_q != '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (!last) begin
                idx_d   = idx_q + 1'b1;
                state_d = LOAD;
            end else if (loop_q) begin
                idx_d   = '0;
                state_d = LOAD;
            end else begin
                state_d = FINISH;
            end
        end

        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            cpp_d   = '0;
            np_d    = (cpp_q != '0);
            done_d  = 1'b1;
        end
    end

    assign clks_per_period = cpp_q;
    assign new_period      = np_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign cur_index       = idx_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a timeline model derived from tick arithmetic predicts every
// output per cycle; a single negedge process compares the DUT and a few literal pins.
module tb_note_sequencer;
    import note_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int GAP     = 2;
    localparam int TPER    = CLK_HZ / TICK_HZ;
    localparam int IDX_W   = 2;
    localparam int LEN_W   = 3;
    localparam int NW      = 192;

    logic                clk = 1'b0;
    logic                reset;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_addr;
    logic [31:0]         wr_period;
    logic [15:0]         wr_dur;
    logic [LEN_W-1:0]    seq_len;
    logic [2:0]          octave;
    logic                start;
    logic                stop;
`ifdef NOTE_SEQ_LOOP_EN
    logic                loop_in;
`endif
    logic [31:0]         cpp;
    logic                new_period;
    logic                busy;
    logic                done;
    logic [IDX_W-1:0]    cur_index;
    state_t              state_dbg;

    note_sequencer #(
        .DEPTH   (DEPTH),
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .GAP_MS  (GAP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_period       (wr_period),
        .wr_dur          (wr_dur),
        .seq_len         (seq_len),
        .octave          (octave),
        .start           (start),
        .stop            (stop),
`ifdef NOTE_SEQ_LOOP_EN
        .loop            (loop_in),
`endif
        .clks_per_period (cpp),
        .new_period      (new_period),
        .busy            (busy),
        .done            (done),
        .cur_index       (cur_index),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    // model state
    logic [31:0] m_per [DEPTH];
    logic [15:0] m_dur [DEPTH];
    logic [31:0] exp_cpp  [NW];
    bit          exp_np   [NW];
    bit          exp_busy [NW];
    bit          exp_done [NW];
    int          exp_idx  [NW];
    bit          exp_ichk [NW];
    bit          pin_cen  [NW];
    logic [31:0] pin_cv   [NW];
    bit          pin_den  [NW];

    int cyc = 0;
    int base = 0;
    bit chk_en = 1'b0;
    int ci;
    int n_vec = 0;
    int n_err = 0;

    function automatic int next_tick(input int x);
        return ((x + TPER - 1) / TPER) * TPER;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < NW; c++) begin
            exp_cpp[c] = '0; exp_np[c] = 1'b0; exp_busy[c] = 1'b0;
            exp_done[c] = 1'b0; exp_idx[c] = 0; exp_ichk[c] = 1'b0;
        end
    endtask

    task automatic clear_pins();
        for (int c = 0; c < NW; c++) begin
            pin_cen[c] = 1'b0; pin_cv[c] = '0; pin_den[c] = 1'b0;
        end
    endtask

    task automatic pin_cpp(input int c, input logic [31:0] v);
        pin_cen[c] = 1'b1;
        pin_cv[c]  = v;
    endtask

    task automatic pin_done(input int c);
        pin_den[c] = 1'b1;
    endtask

    // Cycle 0 = start applied. A note loaded in cycle L sounds from L+1 until the cycle after
    // its d-th tick; the gap spans G ticks; ticks fall at edges that are multiples of TPER.
    task automatic build_model(input int len_in, input int oct, input bit lp,
                               input int stop_at, input int nwin);
        int len, i, lcyc, s, t, u, d;
        bit fin;
        logic [31:0] v;
        clear_model();
        len = (len_in > DEPTH) ? DEPTH : len_in;
        if (len == 0) begin
            exp_done[1] = 1'b1;
        end else begin
            i = 0; lcyc = 1; fin = 1'b0;
            while (!fin && lcyc < nwin) begin
                d = (m_dur[i] == 0) ? 1 : int'(m_dur[i]);
                v = m_per[i] >> oct;
                s = lcyc + 1;
                t = next_tick(s) + TPER * (d - 1);
                u = next_tick(t + 2) + TPER * (GAP - 1);
                for (int c = lcyc; c <= u && c < NW; c++) begin
                    exp_busy[c] = 1'b1; exp_idx[c] = i; exp_ichk[c] = 1'b1;
                end
                for (int c = s; c <= t + 1 && c < NW; c++) exp_cpp[c] = v;
                if (s < NW) exp_np[s] = 1'b1;
                if (t + 2 < NW) exp_np[t + 2] = 1'b1;
                if (i == len - 1 && !lp) begin
                    if (u + 1 < NW) begin
                        exp_busy[u + 1] = 1'b1; exp_idx[u + 1] = i; exp_ichk[u + 1] = 1'b1;
                    end
                    if (u + 2 < NW) exp_done[u + 2] = 1'b1;
                    fin = 1'b1;
                end else begin
                    i = (i + 1) % len;
                    lcyc = u + 1;
                end
            end
        end
        if (stop_at >= 0 && stop_at + 1 < NW && exp_busy[stop_at]) begin
            for (int c = stop_at + 1; c < NW; c++) begin
                exp_cpp[c] = '0; exp_np[c] = 1'b0; exp_busy[c] = 1'b0;
                exp_done[c] = 1'b0; exp_ichk[c] = 1'b0;
            end
            exp_done[stop_at + 1] = 1'b1;
            exp_np[stop_at + 1]   = (exp_cpp[stop_at] != 0);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, ci, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            ci = cyc - base;
            if (ci >= 0 && ci < NW) begin
                chk("cpp", cpp, exp_cpp[ci]);
                chk("new_period", 32'(new_period), 32'(exp_np[ci]));
                chk("busy", 32'(busy), 32'(exp_busy[ci]));
                chk("done", 32'(done), 32'(exp_done[ci]));
                if (exp_ichk[ci]) chk("cur_index", 32'(cur_index), 32'(exp_idx[ci]));
                if (pin_cen[ci]) begin
                    chk("pin_model_cpp", exp_cpp[ci], pin_cv[ci]);
                    chk("pin_dut_cpp", cpp, pin_cv[ci]);
                end
                if (pin_den[ci]) begin
                    chk("pin_model_done", 32'(exp_done[ci]), 32'd1);
                    chk("pin_dut_done", 32'(done), 32'd1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int per, input int dur);
        wr_en = 1'b1; wr_addr = IDX_W'(addr); wr_period = 32'(per); wr_dur = 16'(dur);
        step();
        wr_en = 1'b0;
        m_per[addr] = 32'(per);
        m_dur[addr] = 16'(dur);
    endtask

    task automatic idle_window(input int nwin);
        clear_model();
        clear_pins();
        for (int c = 0; c < nwin; c++) exp_ichk[c] = 1'b1;
        base = cyc;
        chk_en = 1'b1;
        repeat (nwin) step();
        chk_en = 1'b0;
    endtask

    // One playback window; wr_at/stop_at/start2_at < 0 disable those events.
    task automatic run_seq(input int len, input int oct, input bit lp, input int stop_at,
                           input int start2_at, input int wr_at, input int nwin);
        build_model(len, oct, lp, stop_at, nwin);
        for (int c = 0; c < nwin; c++) begin
            if (c == 0) begin
                base = cyc;
                chk_en = 1'b1;
            end
            start     = (c == 0) || (c == start2_at);
            stop      = (c == stop_at);
            seq_len   = (c == 0) ? LEN_W'(len) : '0;
            octave    = (c == 0) ? 3'(oct) : (3'(oct) ^ 3'd3);
            wr_en     = (c == wr_at);
            wr_addr   = '0;
            wr_period = 32'd1234;
            wr_dur    = 16'd7;
`ifdef NOTE_SEQ_LOOP_EN
            loop_in   = (c == 0) ? lp : ~lp;
`endif
            step();
        end
        chk_en = 1'b0;
        start = 1'b0; stop = 1'b0; wr_en = 1'b0; seq_len = '0; octave = '0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
        seq_len = '0; octave = '0; start = 1'b0; stop = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
        loop_in = 1'b0;
`endif
        clear_pins();
        repeat (3) step();
        reset = 1'b0;
        idle_window(4);

        write_entry(0, 8000, 3);
        write_entry(1, 6000, 1);
        write_entry(2, 2000, 1);
        write_entry(3, 1000, 2);

        // two notes, octave 1; a second start at cycle 20 must be ignored
        clear_pins();
        pin_cpp(2, 32'd4000); pin_cpp(31, 32'd4000); pin_cpp(32, 32'd0);
        pin_cpp(52, 32'd3000); pin_cpp(62, 32'd0); pin_done(82);
        run_seq(2, 1, 1'b0, -1, 20, -1, 90);

        // stop while entry 1 is sounding
        clear_pins();
        pin_cpp(55, 32'd3000); pin_cpp(56, 32'd0); pin_done(56);
        run_seq(2, 1, 1'b0, 55, -1, -1, 64);

        // replay from entry 0 with seq_len beyond DEPTH (saturates to 4 entries)
        clear_pins();
        pin_cpp(2, 32'd8000); pin_cpp(112, 32'd1000); pin_done(152);
        run_seq(7, 0, 1'b0, -1, -1, -1, 160);

        // empty sequence
        clear_pins();
        pin_done(1);
        run_seq(0, 0, 1'b0, -1, -1, -1, 6);

        // write to the playing entry is dropped; start+stop together aborts
        clear_pins();
        pin_cpp(25, 32'd2000); pin_cpp(26, 32'd0); pin_done(26);
        run_seq(1, 2, 1'b0, 25, 25, 5, 32);
        clear_pins();
        pin_cpp(2, 32'd8000); pin_done(52);
        run_seq(1, 0, 1'b0, -1, -1, -1, 56);

        // zero duration plays one tick; a stop after completion is ignored
        write_entry(0, 5000, 0);
        clear_pins();
        pin_cpp(2, 32'd5000); pin_cpp(11, 32'd5000); pin_cpp(12, 32'd0); pin_done(32);
        run_seq(1, 0, 1'b0, 36, -1, -1, 40);

`ifdef NOTE_SEQ_LOOP_EN
        clear_pins();
        pin_cpp(62, 32'd5000); pin_cpp(92, 32'd6000); pin_done(131);
        run_seq(2, 0, 1'b1, 130, -1, -1, 135);
`endif

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
